proc_sequencer: RTL and testbench
=================================

// Module: proc_sequencer
// PURPOSE
// Instruction issuer for the 4-register processor: drives its w/F/Rx/Ry/Data inputs and consumes its Done.
// Holds a small program memory, loaded through a write port. On Start it issues each instruction in
// order: pulse w, hold operands until Done, advance. Sits between testbench/host logic and proc, on proc's Clock.
// PARAMETERS
// DEPTH    16   program memory entries (power of two)
// AW       4    address width, log2(DEPTH)
// TIMEOUT  15   max cycles to wait for Done after issue before flagging Error (>=4)
// PORTS
// Clock      in   1   system clock, rising edge
// Reset      in   1   asynchronous, active-high reset
// LoadEn     in   1   write LoadWord into program memory at LoadAddr (accepted only in IDLE/HALT/ERROR)
// LoadAddr   in   AW  program memory write address
// LoadWord   in   14  {F[1:0], Rx[1:0], Ry[1:0], Data[7:0]}
// Length     in   AW+1 number of instructions to run (0..DEPTH), sampled on Start
// Start      in   1   begin execution at address 0 (accepted only in IDLE/HALT/ERROR)
// ProcDone   in   1   Done from proc
// w          out  1   instruction-valid pulse to proc
// F          out  2   opcode to proc (00 load, 01 move, 10 add, 11 sub)
// Rx, Ry     out  2   register selects to proc
// Data       out  8   external data to proc (used by load)
// Busy       out  1   high from Start accept until HALT/ERROR
// Halted     out  1   high in HALT (program completed)
// Error      out  1   high in ERROR (Done timeout)
// PC         out  AW+1 index of instruction currently issued / next to issue
// BEHAVIOUR
// - Reset (any time, incl. mid-instruction): state IDLE; w,F,Rx,Ry,Data,PC,Busy,Halted,Error = 0.
//   Program memory contents are not cleared by Reset.
// - All outputs registered; program memory is a synchronous-write, combinational-read array.
// - FSM states: IDLE, ISSUE, WAIT, NEXT, HALT, ERROR.
//   IDLE/HALT/ERROR: Start -> latch Length; PC<=0; clear Halted/Error; go ISSUE if Length!=0 else HALT.
//     Start wins over LoadEn in the same cycle (the load is dropped).
//   ISSUE (1 cycle): w=1; F/Rx/Ry/Data <= mem[PC] (registered on entry, so stable the whole cycle w=1).
//     Timeout counter <= 0. Go WAIT. ProcDone ignored in this cycle.
//   WAIT: w=0; F/Rx/Ry/Data held unchanged (proc reads Data at its T1). Counter increments each cycle.
//     ProcDone=1 -> NEXT. Else counter==TIMEOUT -> ERROR. Done has priority if both in same cycle.
//   NEXT (1 cycle): PC<=PC+1; if PC+1==Length -> HALT else ISSUE. Gives proc one cycle at T0 w/ w=0
//     so its counter clears before the next w pulse.
//   HALT: Halted=1, Busy=0, PC==Length. ERROR: Error=1, Busy=0, PC holds failing instruction index.
// - Expected proc latency: Done 2 cycles after w for load/move, 4 cycles for add/sub (counting w cycle as 1).
//   Per-instruction issue period: load/move 4 cycles, add/sub 6 cycles.
// - LoadEn during Busy is ignored (memory unchanged). Length > DEPTH is saturated to DEPTH.
// - PC is AW+1 bits so PC==DEPTH is representable at completion; no wrap-around.
// - Start while Busy is ignored. ProcDone outside WAIT is ignored.
// - w is never high for more than one consecutive cycle.
// TESTING
// 1. Reset asserted mid-WAIT -> all outputs 0 same cycle (async), IDLE; next Start reruns from PC=0.
// 2. Load {00,00,00,8'h05},{00,01,00,8'h03},{10,00,01,0}; Length=3; Start, with real proc ->
//    w pulses at cycles 1,5,9; Halted after add done; proc R0=8'h08; PC=3.
// 3. Sub: R0=8'h02, R1=8'h05, {11,00,01} -> R0=8'hFD (wrap); Done 4 cycles after w; next w 2 cycles later.
// 4. ProcDone tied 0, Length=1, TIMEOUT=15 -> Error=1 exactly 16 cycles after w; PC=0; Busy=0.
// 5. Length=0 Start -> Halted next cycle, w never pulses; Start+LoadEn same cycle -> memory unchanged.
// 6. LoadEn during Busy -> program memory unchanged; Start during Busy -> no restart, PC sequence intact.

Source files
------------

// File: rtl/proc_sequencer.sv
// proc_sequencer: instruction issuer for the 4-register processor.
// Holds a small program memory loaded through a write port. On Start it issues
// each stored instruction in order: one-cycle w pulse, operands held until the
// processor answers with Done, one spacer cycle, then the next instruction.
// All outputs are registered; the timeout counter flags a processor that never
// answers.
module proc_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [13:0]   LoadWord,
    input  logic [AW:0]   Length,
    input  logic          Start,
    input  logic          ProcDone,
    output logic          w,
    output logic [1:0]    F,
    output logic [1:0]    Rx,
    output logic [1:0]    Ry,
    output logic [7:0]    Data,
    output logic          Busy,
    output logic          Halted,
    output logic          Error,
    output logic [AW:0]   PC
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        HALT  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [13:0]   mem [DEPTH];
    logic [AW:0]   len;
    logic [AW:0]   len_nx;
    logic [AW:0]   len_sat;
    logic [AW:0]   pc_nx;
    logic [CW-1:0] cnt;
    logic          idle_like;
    logic          w_nx;
    logic          busy_nx;
    logic          halted_nx;
    logic          error_nx;
    logic [13:0]   word_nx;

    // Length requests beyond the memory depth run the whole memory once.
    always_comb begin
        len_sat = (Length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : Length;
    end

    // States that accept Start and program loads.
    always_comb begin
        idle_like = (state == IDLE) || (state == HALT) || (state == ERROR);
    end

    // Program memory write; a simultaneous Start takes precedence and drops the load.
    always_ff @(posedge Clock) begin
        if (LoadEn && idle_like && !Start) begin
            mem[LoadAddr] <= LoadWord;
        end
    end

    // Next state, next program counter and latched run length.
    always_comb begin
        state_nx = state;
        pc_nx    = PC;
        len_nx   = len;
        case (state)
            IDLE, HALT, ERROR: begin
                if (Start) begin
                    len_nx   = len_sat;
                    pc_nx    = '0;
                    state_nx = (len_sat != '0) ? ISSUE : HALT;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (ProcDone) begin
                    state_nx = NEXT;
                end else if (cnt == CW'(TIMEOUT)) begin
                    state_nx = ERROR;
                end
            end
            NEXT: begin
                pc_nx    = PC + 1'b1;
                state_nx = (pc_nx == len) ? HALT : ISSUE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered.
    always_comb begin
        w_nx      = (state_nx == ISSUE);
        busy_nx   = (state_nx == ISSUE) || (state_nx == WAIT) || (state_nx == NEXT);
        halted_nx = (state_nx == HALT);
        error_nx  = (state_nx == ERROR);
        word_nx   = {F, Rx, Ry, Data};
        if (state_nx == ISSUE) begin
            word_nx = mem[pc_nx[AW-1:0]];
        end
    end

    // State, outputs and timeout counter registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            PC     <= '0;
            len    <= '0;
            cnt    <= '0;
            w      <= 1'b0;
            Busy   <= 1'b0;
            Halted <= 1'b0;
            Error  <= 1'b0;
            F      <= '0;
            Rx     <= '0;
            Ry     <= '0;
            Data   <= '0;
        end else begin
            state  <= state_nx;
            PC     <= pc_nx;
            len    <= len_nx;
            w      <= w_nx;
            Busy   <= busy_nx;
            Halted <= halted_nx;
            Error  <= error_nx;
            {F, Rx, Ry, Data} <= word_nx;
            // Counter is zero during the w cycle and counts every cycle after it.
            if (state_nx == ISSUE) begin
                cnt <= '0;
            end else if (state_nx == WAIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Testbench for proc_sequencer: a behavioural processor answers each w pulse
// with Done (2 cycles for load/move, 4 for add/sub) and keeps a register file.
// Stimulus pushes expected issues and completions into queues; a monitor pops
// and compares them whenever the sequencer presents a w pulse or a Halted/Error edge.
module tb_proc_sequencer;

    logic        Clock    = 1'b0;
    logic        Reset    = 1'b0;
    logic        LoadEn   = 1'b0;
    logic [3:0]  LoadAddr = '0;
    logic [13:0] LoadWord = '0;
    logic [4:0]  Length   = '0;
    logic        Start    = 1'b0;
    logic        ProcDone = 1'b0;
    logic        w;
    logic [1:0]  F;
    logic [1:0]  Rx;
    logic [1:0]  Ry;
    logic [7:0]  Data;
    logic        Busy;
    logic        Halted;
    logic        Error;
    logic [4:0]  PC;

    proc_sequencer dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .LoadEn   (LoadEn),
        .LoadAddr (LoadAddr),
        .LoadWord (LoadWord),
        .Length   (Length),
        .Start    (Start),
        .ProcDone (ProcDone),
        .w        (w),
        .F        (F),
        .Rx       (Rx),
        .Ry       (Ry),
        .Data     (Data),
        .Busy     (Busy),
        .Halted   (Halted),
        .Error    (Error),
        .PC       (PC)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int          rel;
        logic [13:0] word;
        logic [4:0]  pc;
    } issue_t;

    typedef struct {
        int         rel;
        logic       err;
        logic [4:0] pc;
    } end_t;

    issue_t      exp_issue[$];
    end_t        exp_end[$];
    int          checks = 0;
    int          errors = 0;
    int          start_cyc = 0;
    logic [13:0] tb_mem [16];
    logic        proc_en = 1'b1;
    logic [7:0]  r [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural processor: latches the instruction on w, raises Done later, updates registers.
    logic        pend = 1'b0;
    int          done_at = 0;
    logic [13:0] p_word = '0;
    always @(negedge Clock) begin
        ProcDone = 1'b0;
        if (Reset) begin
            pend = 1'b0;
        end else begin
            if (pend && cyc == done_at) begin
                ProcDone = 1'b1;
                pend = 1'b0;
                case (p_word[13:12])
                    2'b00: r[p_word[11:10]] = p_word[7:0];
                    2'b01: r[p_word[11:10]] = r[p_word[9:8]];
                    2'b10: r[p_word[11:10]] = r[p_word[11:10]] + r[p_word[9:8]];
                    default: r[p_word[11:10]] = r[p_word[11:10]] - r[p_word[9:8]];
                endcase
            end
            if (w && proc_en) begin
                pend    = 1'b1;
                p_word  = {F, Rx, Ry, Data};
                done_at = cyc + (F[1] ? 4 : 2);
            end
        end
    end

    // Monitor: compares each w pulse and each Halted/Error rising edge with the queues.
    logic        w_prev = 1'b0;
    logic        halt_prev = 1'b0;
    logic        err_prev = 1'b0;
    logic [13:0] last_word = '0;
    issue_t      ie;
    end_t        ee;
    int          rel;
    always @(negedge Clock) begin
        if (Reset) begin
            w_prev    = 1'b0;
            halt_prev = 1'b0;
            err_prev  = 1'b0;
        end else begin
            rel = cyc - start_cyc + 1;
            if (w) begin
                chk("w_single_cycle", 32'(w_prev), 32'd0);
                if (exp_issue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_unexpected actual=w_high PC=%0d required=no_issue_pending", PC);
                end else begin
                    ie = exp_issue.pop_front();
                    chk("issue_cycle", 32'(rel), 32'(ie.rel));
                    chk("issue_word", 32'({F, Rx, Ry, Data}), 32'(ie.word));
                    chk("issue_pc", 32'(PC), 32'(ie.pc));
                    chk("issue_busy", 32'(Busy), 32'd1);
                end
                last_word = {F, Rx, Ry, Data};
            end else if (Busy) begin
                chk("hold_operands", 32'({F, Rx, Ry, Data}), 32'(last_word));
            end
            if ((Halted && !halt_prev) || (Error && !err_prev)) begin
                if (exp_end.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL end_unexpected actual=Halted%0b_Error%0b required=no_end_pending", Halted, Error);
                end else begin
                    ee = exp_end.pop_front();
                    chk("end_cycle", 32'(rel), 32'(ee.rel));
                    chk("end_flags", 32'({Halted, Error}), ee.err ? 32'd1 : 32'd2);
                    chk("end_pc", 32'(PC), 32'(ee.pc));
                    chk("end_busy", 32'(Busy), 32'd0);
                end
            end
            w_prev    = w;
            halt_prev = Halted;
            err_prev  = Error;
        end
    end

    task automatic load_word(input logic [3:0] a, input logic [13:0] wd);
        @(negedge Clock);
        LoadEn = 1'b1; LoadAddr = a; LoadWord = wd;
        tb_mem[a] = wd;
        @(negedge Clock);
        LoadEn = 1'b0;
    endtask

    task automatic poke_ignored(input logic [3:0] a, input logic [13:0] wd);
        @(negedge Clock);
        LoadEn = 1'b1; LoadAddr = a; LoadWord = wd;
        @(negedge Clock);
        LoadEn = 1'b0;
    endtask

    // Issues Start and queues the hand-timed expectations: load/move 4 cycles, add/sub 6.
    task automatic start_run(input int len, input logic done_en, input logic want_end, input logic poke);
        int   l;
        int   t;
        logic stop;
        logic [31:0] len_v;
        l = (len > 16) ? 16 : len;
        t = 1;
        stop = 1'b0;
        len_v = 32'(len);
        proc_en = done_en;
        @(negedge Clock);
        Start = 1'b1;
        Length = len_v[4:0];
        if (poke) begin
            LoadEn = 1'b1; LoadAddr = 4'd0; LoadWord = 14'h3FFF;
        end
        start_cyc = cyc + 1;
        for (int i = 0; i < l && !stop; i++) begin
            exp_issue.push_back('{t, tb_mem[i], 5'(i)});
            if (!done_en) begin
                if (want_end) exp_end.push_back('{t + 16, 1'b1, 5'(i)});
                stop = 1'b1;
            end else begin
                t += tb_mem[i][13] ? 6 : 4;
            end
        end
        if (!stop && want_end) exp_end.push_back('{t, 1'b0, 5'(l)});
        @(negedge Clock);
        Start = 1'b0;
        LoadEn = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_issue.size() == 0 && exp_end.size() == 0) break;
            @(negedge Clock);
        end
        chk("drain", 32'(exp_issue.size() + exp_end.size()), 32'd0);
        repeat (2) @(negedge Clock);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        foreach (r[i]) r[i] = 8'h00;
        #1 Reset = 1'b1;
        #2;
        chk("reset_w", 32'(w), 32'd0);
        chk("reset_pc", 32'(PC), 32'd0);
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_halted", 32'(Halted), 32'd0);
        chk("reset_error", 32'(Error), 32'd0);
        chk("reset_operands", 32'({F, Rx, Ry, Data}), 32'd0);
        @(negedge Clock); #2 Reset = 1'b0;

        // Program: R0<=5, R1<=3, R0<=R0+R1.
        load_word(4'd0, {2'b00, 2'b00, 2'b00, 8'h05});
        load_word(4'd1, {2'b00, 2'b01, 2'b00, 8'h03});
        load_word(4'd2, {2'b10, 2'b00, 2'b01, 8'h00});

        // Reset while waiting for Done on the add.
        start_run(3, 1'b1, 1'b0, 1'b0);
        while (cyc - start_cyc + 1 < 10) @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        chk("midwait_rst_w", 32'(w), 32'd0);
        chk("midwait_rst_pc", 32'(PC), 32'd0);
        chk("midwait_rst_busy", 32'(Busy), 32'd0);
        chk("midwait_rst_halted", 32'(Halted), 32'd0);
        chk("midwait_rst_error", 32'(Error), 32'd0);
        chk("midwait_rst_operands", 32'({F, Rx, Ry, Data}), 32'd0);
        chk("midwait_issues_seen", 32'(exp_issue.size()), 32'd0);
        repeat (2) @(negedge Clock);
        #2 Reset = 1'b0;

        // Full run of the add program.
        start_run(3, 1'b1, 1'b1, 1'b0);
        wait_done(100);
        chk("add_r0", 32'(r[0]), 32'h08);
        chk("add_r1", 32'(r[1]), 32'h03);
        chk("add_pc", 32'(PC), 32'd3);
        chk("add_halted", 32'(Halted), 32'd1);

        // Subtract with wrap, followed by a load two cycles after Done.
        load_word(4'd0, {2'b00, 2'b00, 2'b00, 8'h02});
        load_word(4'd1, {2'b00, 2'b01, 2'b00, 8'h05});
        load_word(4'd2, {2'b11, 2'b00, 2'b01, 8'h00});
        load_word(4'd3, {2'b00, 2'b10, 2'b00, 8'hAA});
        start_run(4, 1'b1, 1'b1, 1'b0);
        wait_done(100);
        chk("sub_r0", 32'(r[0]), 32'hFD);
        chk("sub_r2", 32'(r[2]), 32'hAA);
        chk("sub_pc", 32'(PC), 32'd4);

        // Processor never answers: Error 16 cycles after w.
        start_run(1, 1'b0, 1'b1, 1'b0);
        wait_done(100);
        chk("timeout_error", 32'(Error), 32'd1);
        chk("timeout_pc", 32'(PC), 32'd0);
        chk("timeout_busy", 32'(Busy), 32'd0);

        // Empty program halts at once without any w.
        start_run(0, 1'b1, 1'b1, 1'b0);
        wait_done(20);
        chk("empty_halted", 32'(Halted), 32'd1);
        chk("empty_pc", 32'(PC), 32'd0);
        chk("empty_error", 32'(Error), 32'd0);

        // Start together with LoadEn: the load is dropped, mem[0] still issues its old word.
        start_run(1, 1'b1, 1'b1, 1'b1);
        wait_done(50);
        chk("startload_r0", 32'(r[0]), 32'h02);

        // Load and Start while busy are both ignored.
        start_run(4, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge Clock);
        poke_ignored(4'd3, 14'h0055);
        @(negedge Clock);
        Start = 1'b1; Length = 5'd1;
        @(negedge Clock);
        Start = 1'b0;
        wait_done(100);
        chk("busy_r0", 32'(r[0]), 32'hFD);
        chk("busy_r2", 32'(r[2]), 32'hAA);
        chk("busy_pc", 32'(PC), 32'd4);

        // Length 17 saturates to the full 16-entry memory; ends with a move.
        for (int i = 4; i < 15; i++) load_word(4'(i), {2'b00, 2'b11, 2'b00, 8'(i)});
        load_word(4'd15, {2'b01, 2'b00, 2'b11, 8'h00});
        start_run(17, 1'b1, 1'b1, 1'b0);
        wait_done(200);
        chk("sat_pc", 32'(PC), 32'd16);
        chk("sat_r3", 32'(r[3]), 32'h0E);
        chk("sat_move_r0", 32'(r[0]), 32'h0E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
